// File: rtl/goal_sequencer.sv
// goal_sequencer: rally sequencer between the top-level game FSM and the
// ball/player datapath.
//
// Purpose
//   Detects goals from the ball-in-goal levels and keeps both scores. After
//   a goal, play is frozen for a fixed number of frames. The sequencer then
//   pulses an entity reset and runs a 3-2-1 kickoff countdown before motion
//   is enabled again. When either score reaches WIN_SCORE the match is over.
//
// Ports
//   CLK          in   system clock, all state changes on posedge
//   Reset        in   asynchronous active-high reset
//   frame_tick   in   one-cycle pulse per video frame
//   game_active  in   level, high while a match is in progress
//   new_match    in   one-cycle pulse, clears scores and restarts kickoff
//   left_hit     in   level, ball inside left goal (point to right player)
//   right_hit    in   level, ball inside right goal (point to left player)
//   score_left   out  left player score
//   score_right  out  right player score
//   play_enable  out  high only while play is running
//   entity_reset out  one-cycle pulse, return ball/players to start
//   goal_flag    out  {left_scored, right_scored}, nonzero only while frozen
//   countdown    out  3,2,1 during kickoff, 0 otherwise
//   match_over   out  high once a player has reached WIN_SCORE
//   winner       out  valid with match_over: 0 = left, 1 = right
//
// Every output is decoded from registered state, so there is no
// combinational path from any input to any output.

module goal_sequencer #(
   parameter int SCORE_W        = 3,
   parameter int WIN_SCORE      = 5,
   parameter int FREEZE_FRAMES  = 60,
   parameter int TICKS_PER_STEP = 30
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic               frame_tick,
   input  logic               game_active,
   input  logic               new_match,
   input  logic               left_hit,
   input  logic               right_hit,
   output logic [SCORE_W-1:0] score_left,
   output logic [SCORE_W-1:0] score_right,
   output logic               play_enable,
   output logic               entity_reset,
   output logic [1:0]         goal_flag,
   output logic [1:0]         countdown,
   output logic               match_over,
   output logic               winner
);

   // One shared frame counter serves both the freeze and the kickoff
   // phases, so it is sized for the longer of the two.
   localparam int CNT_MAX = (FREEZE_FRAMES > TICKS_PER_STEP) ?
                            FREEZE_FRAMES : TICKS_PER_STEP;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] FRZ_LAST  = CNT_W'(FREEZE_FRAMES - 1);
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(TICKS_PER_STEP - 1);

   localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
   localparam logic [SCORE_W-1:0] ONE = SCORE_W'(1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_RESET_POS = 3'd1;
   localparam logic [2:0] S_KICKOFF   = 3'd2;
   localparam logic [2:0] S_PLAY      = 3'd3;
   localparam logic [2:0] S_FREEZE    = 3'd4;
   localparam logic [2:0] S_OVER      = 3'd5;

   logic [2:0]         state_q, state_d;
   logic [SCORE_W-1:0] score_left_q, score_left_d;
   logic [SCORE_W-1:0] score_right_q, score_right_d;
   logic [1:0]         goal_flag_q, goal_flag_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         digit_q, digit_d;
   logic               left_prev_q, left_prev_d;
   logic               right_prev_q, right_prev_d;

   logic left_edge;
   logic right_edge;
   logic win_reached;

   assign left_edge   = left_hit & ~left_prev_q;
   assign right_edge  = right_hit & ~right_prev_q;
   assign win_reached = (score_left_q == WIN) || (score_right_q == WIN);

   always_comb begin
      state_d       = state_q;
      score_left_d  = score_left_q;
      score_right_d = score_right_q;
      goal_flag_d   = goal_flag_q;
      cnt_d         = cnt_q;
      digit_d       = digit_q;
      // Hit history tracks the levels in every state, so a hit that is
      // already high when play starts never looks like a fresh edge.
      left_prev_d   = left_hit;
      right_prev_d  = right_hit;

      if (new_match) begin
         score_left_d  = '0;
         score_right_d = '0;
         goal_flag_d   = 2'b00;
         cnt_d         = '0;
         state_d       = game_active ? S_RESET_POS : S_IDLE;
      end else if (!game_active && (state_q != S_OVER)) begin
         // Scores are kept; the flag must not survive outside FREEZE.
         goal_flag_d = 2'b00;
         state_d     = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_RESET_POS;
            end

            S_RESET_POS: begin
               cnt_d   = '0;
               digit_d = 2'd3;
               state_d = S_KICKOFF;
            end

            S_KICKOFF: begin
               if (frame_tick) begin
                  if (cnt_q == STEP_LAST) begin
                     cnt_d = '0;
                     if (digit_q == 2'd1) begin
                        state_d = S_PLAY;
                     end else begin
                        digit_d = digit_q - 2'd1;
                     end
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end

            S_PLAY: begin
               if (left_edge && right_edge) begin
                  // Simultaneous goals are ambiguous: replay the rally.
                  state_d = S_RESET_POS;
               end else if (right_edge) begin
                  if (score_left_q < WIN) begin
                     score_left_d = score_left_q + ONE;
                  end
                  goal_flag_d = 2'b10;
                  cnt_d       = '0;
                  state_d     = S_FREEZE;
               end else if (left_edge) begin
                  if (score_right_q < WIN) begin
                     score_right_d = score_right_q + ONE;
                  end
                  goal_flag_d = 2'b01;
                  cnt_d       = '0;
                  state_d     = S_FREEZE;
               end
            end

            S_FREEZE: begin
               if (frame_tick) begin
                  if (cnt_q == FRZ_LAST) begin
                     cnt_d       = '0;
                     goal_flag_d = 2'b00;
                     state_d     = win_reached ? S_OVER : S_RESET_POS;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end

            S_OVER: begin
               state_d = S_OVER;
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q       <= S_IDLE;
         score_left_q  <= '0;
         score_right_q <= '0;
         goal_flag_q   <= 2'b00;
         cnt_q         <= '0;
         digit_q       <= 2'd0;
         left_prev_q   <= 1'b0;
         right_prev_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         score_left_q  <= score_left_d;
         score_right_q <= score_right_d;
         goal_flag_q   <= goal_flag_d;
         cnt_q         <= cnt_d;
         digit_q       <= digit_d;
         left_prev_q   <= left_prev_d;
         right_prev_q  <= right_prev_d;
      end
   end

   assign score_left   = score_left_q;
   assign score_right  = score_right_q;
   assign goal_flag    = goal_flag_q;
   assign play_enable  = (state_q == S_PLAY);
   assign entity_reset = (state_q == S_RESET_POS);
   assign match_over   = (state_q == S_OVER);
   assign countdown    = (state_q == S_KICKOFF) ? digit_q : 2'd0;
   assign winner       = (state_q == S_OVER) && (score_right_q == WIN);

endmodule
